// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared up or up/down period counter, per-channel
// duty compare, and a shadowed configuration port that only takes effect at period boundaries.
module pwm_multi_ch #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CNT_W-1:0]          cfg_tc,
  input  logic                      cfg_center,
  input  logic [CHANNELS*CNT_W-1:0] cfg_duty,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Period counter and direction (down_q=1 only on the falling half in center mode)
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      down_q, down_d;

  // Active configuration, used by the counter and compare
  logic [CNT_W-1:0]          tc_a_q, tc_a_d;
  logic                      center_a_q, center_a_d;
  logic [CHANNELS*CNT_W-1:0] duty_a_q, duty_a_d;

  // Shadow configuration, filled by the write port
  logic [CNT_W-1:0]          tc_s_q, tc_s_d;
  logic                      center_s_q, center_s_d;
  logic [CHANNELS*CNT_W-1:0] duty_s_q, duty_s_d;
  logic                      pending_q, pending_d;

  // Registered outputs
  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      ps_q, ps_d;

  logic                      accept;
  logic                      at_top;
  logic                      boundary;

  assign cfg_ready    = !pending_q;
  assign accept       = cfg_valid && !pending_q;
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

  // Last count of the current period; an idle cycle always counts as one so
  // pending configuration lands while the outputs are parked.
  always_comb begin
    at_top = (cnt_q == tc_a_q);
    if (!enable) begin
      boundary = 1'b1;
    end else if (center_a_q) begin
      boundary = (tc_a_q == '0)
              || (down_q && (cnt_q == ONE))
              || (!down_q && at_top && (tc_a_q == ONE));
    end else begin
      boundary = at_top;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    down_d = down_q;
    if (boundary) begin
      cnt_d  = '0;
      down_d = 1'b0;
    end else if (!center_a_q) begin
      cnt_d = cnt_q + ONE;
    end else if (down_q) begin
      cnt_d = cnt_q - ONE;
    end else if (at_top) begin
      cnt_d  = cnt_q - ONE;
      down_d = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // A write can never coincide with a shadow-to-active transfer: accept
  // requires an empty shadow, so fresh data always waits for the next boundary.
  always_comb begin
    tc_a_d     = tc_a_q;
    center_a_d = center_a_q;
    duty_a_d   = duty_a_q;
    tc_s_d     = tc_s_q;
    center_s_d = center_s_q;
    duty_s_d   = duty_s_q;
    pending_d  = pending_q;
    if (boundary && pending_q) begin
      tc_a_d     = tc_s_q;
      center_a_d = center_s_q;
      duty_a_d   = duty_s_q;
      pending_d  = 1'b0;
    end
    if (accept) begin
      tc_s_d     = cfg_tc;
      center_s_d = cfg_center;
      duty_s_d   = cfg_duty;
      pending_d  = 1'b1;
    end
  end

  // Compare stage: outputs lag the counter by one clock
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = enable && (cnt_q < duty_a_q[i*CNT_W +: CNT_W]);
    end
    ps_d = enable && (cnt_q == '0) && !down_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      down_q     <= 1'b0;
      tc_a_q     <= '0;
      center_a_q <= 1'b0;
      duty_a_q   <= '0;
      tc_s_q     <= '0;
      center_s_q <= 1'b0;
      duty_s_q   <= '0;
      pending_q  <= 1'b0;
      pwm_q      <= '0;
      ps_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      down_q     <= down_d;
      tc_a_q     <= tc_a_d;
      center_a_q <= center_a_d;
      duty_a_q   <= duty_a_d;
      tc_s_q     <= tc_s_d;
      center_s_q <= center_s_d;
      duty_s_q   <= duty_s_d;
      pending_q  <= pending_d;
      pwm_q      <= pwm_d;
      ps_q       <= ps_d;
    end
  end

endmodule

// File: doc/pwm_multi_ch.md
# pwm_multi_ch

Multi-channel PWM generator that drives CHANNELS outputs from one shared period counter. The period, the per-channel duty cycles and the alignment mode (edge or center) are all set at run time. New configuration is written through a valid/ready port into shadow registers and takes effect only at a period boundary, so output waveforms never glitch. The block sits between a register/control interface and motor, LED or power-stage drivers.

## Interface
- CHANNELS, default 4: number of PWM outputs.
- CNT_W, default 8: width of the counter, period and duty fields.
- clk  in  1: single clock; all logic is on the rising edge.
- reset  in  1: synchronous, active-high reset.
- enable  in  1: run control; 0 holds the counter idle.
- cfg_valid  in  1: configuration write request.
- cfg_ready  out  1: high when the shadow registers are empty and a write can be accepted.
- cfg_tc  in  CNT_W: terminal count TC.
- cfg_center  in  1: 1 selects center-aligned mode, 0 selects edge-aligned mode.
- cfg_duty  in  CHANNELS*CNT_W: duty values; channel i occupies bits [i*CNT_W +: CNT_W].
- pwm_out  out  CHANNELS: registered PWM outputs.
- period_start  out  1: registered one-cycle pulse marking the first count of each period.

## Operation
- Active registers: tc_a, center_a, duty_a[i]. Shadow registers: tc_s, center_s, duty_s[i], plus a pending flag.
- cfg_ready = !pending.
- A write is accepted when cfg_valid && cfg_ready. On acceptance the shadow registers are loaded and pending is set to 1.
- Edge mode:
  - The counter counts 0..tc_a, then wraps to 0.
  - Period length is tc_a+1 clocks.
- Center mode:
  - The counter counts up 0..tc_a, then down tc_a-1..1, then returns to 0 counting up.
  - Period length is 2*tc_a clocks.
  - If tc_a=0 the counter holds at 0.
- Boundary cycle: the last count of a period (edge mode: cnt==tc_a; center mode: counting down with cnt==1, or tc_a==0).
  - At the boundary edge, if pending=1, the active registers load from shadow and pending clears.
  - The counter restarts at 0, counting up.
  - The new TC and mode govern the new period.
- Compare, per channel, where t is the clock cycle:
  - pwm_out[i](t+1) = enable(t) && (cnt(t) < duty_a[i](t)), using an unsigned CNT_W compare.
  - duty=0 gives 0% duty; duty>tc_a gives 100% duty.
- period_start(t+1) = enable(t) && cnt(t)==0 && direction up.
- enable=0:
  - The counter is forced to 0 with direction up, and pwm_out and period_start go to 0 on the next edge.
  - Every idle cycle counts as a boundary, so a pending configuration is applied on the next edge.
- When enable rises, counting starts from 0, and the first period_start appears one cycle later.
- Simultaneous acceptance and boundary: the boundary uses the old shadow contents (none, since ready implied empty). The newly accepted data waits for the next boundary.

## Timing
- Reset values:
  - counter = 0, direction up.
  - tc_a = 0, center_a = 0, all duty_a = 0.
  - Shadow registers = 0, pending = 0.
  - pwm_out = 0, period_start = 0, cfg_ready = 1 on the cycle after reset.
- Reset asserted mid-operation clears everything, including a pending configuration, at the next edge.
- Output latency: one clock from counter value to pwm_out and period_start.
- Configuration latency:
  - If idle: accepted at edge t, active from edge t+1, visible on outputs from t+2.
  - If running: active from the first count of the next period.
- cfg_ready falls the cycle after acceptance and rises the cycle after the boundary that applies the configuration.
- The master must hold cfg_valid and its data stable until ready is seen.
- All arithmetic is unsigned CNT_W; the counter never exceeds tc_a.

## Test plan
- Reset, then release: pwm_out=4'b0000, period_start=0, cfg_ready=1. With enable=1 and no writes, outputs stay 0 and period_start pulses every clock (tc_a=0).
- Edge mode, TC=9, duties {255,10,3,0} (ch3..ch0), enable=1:
  - ch0 is constant 0.
  - ch1 is high for 3 of every 10 clocks, aligned to period_start.
  - ch2 and ch3 are constant 1.
  - period_start has a 10-clock spacing.
- Center mode, TC=4, duty ch0=2: the period is 8 clocks with count sequence 0,1,2,3,4,3,2,1. ch0 is high at counts 0,1 and the final 1, i.e. 3 of 8 clocks, symmetric about the count of 4.
- Mid-period update:
  - Setup: edge mode, TC=9, duty ch0=3, running.
  - Stimulus: write duty=7 when count=5, then hold a second write with duty=1 valid.
  - Required response:
    - The current period shows 3 high clocks, the next period 7, the one after that 1.
    - cfg_ready is low from the first acceptance until the boundary.
    - The second write is accepted the cycle after the boundary.
- Enable dropped at count 6 with a write pending: pwm_out=0 next cycle, and the configuration is applied within 1 clock. Enable raised again: period_start after 1 clock, with the new duty in effect.
- reset asserted for 1 cycle mid-period with pending=1: all outputs are 0, cfg_ready=1, and the pending configuration is discarded (tc_a=0 afterwards).
